// File: rtl/sw_engine_if.sv
// Bus bundle between the unit-propagation slice and its neighbours
// (unit-clause arbiter, clause arbiter, switch).
interface sw_engine_if #(
   parameter int LIT_W = 11,
   parameter int CLA_W = 33
);
   logic [LIT_W-1:0] uca2ucq;
   logic             push;
   logic [CLA_W-1:0] carb2sw;
   logic             carb2sw_valid;
   logic             ucarb2UCQ_in_pop;
   logic [LIT_W-1:0] UCQ_in_dout;
   logic             UCQ_in_empty;
   logic             clq_pop;
   logic [CLA_W-1:0] clq2sw;
   logic             clq_empty;
   logic             UCQ_out_full;
   logic             conflict;
   logic             overflow;

   modport master (
      output uca2ucq, push, carb2sw, carb2sw_valid, ucarb2UCQ_in_pop, clq_pop,
      input  UCQ_in_dout, UCQ_in_empty, clq2sw, clq_empty, UCQ_out_full,
             conflict, overflow
   );

   modport slave (
      input  uca2ucq, push, carb2sw, carb2sw_valid, ucarb2UCQ_in_pop, clq_pop,
      output UCQ_in_dout, UCQ_in_empty, clq2sw, clq_empty, UCQ_out_full,
             conflict, overflow
   );
endinterface

// File: rtl/sw_engine_top.sv
// Unit-propagation slice: UCQ_out feeds the assigned literal, each clause is
// simplified against it and routed to CLQ and, for new units, to UCQ_in.
module sw_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   // A full FIFO refuses the write even when it is popped on the same edge.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;
   assign dout  = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
            wr_ptr_reg          <= wr_ptr_reg + 1'b1;
         end
         if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

module sw_engine_top #(
   parameter int LIT_W = 11,
   parameter int CLA_W = 33,
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   sw_engine_if.slave  bus
);
   logic [LIT_W-1:0] cur_lit_reg, cur_lit_next;
   logic             active_reg, active_next;
   logic             conflict_reg, overflow_reg;

   logic [LIT_W-1:0] ucq_out_dout;
   logic             ucq_out_empty, ucq_out_pop;
   logic             clq_full, ucq_in_full;
   logic             clq_wr, ucq_in_wr, conflict_set;
   logic [CLA_W-1:0] clq_data;

   logic [LIT_W-1:0] neg_lit;
   logic [LIT_W-1:0] lit [3];
   logic [LIT_W-1:0] red [3];
   logic [2:0]       sat;
   logic [2:0]       nz;
   logic [1:0]       nz_cnt;
   logic [CLA_W-1:0] red_clause;
   logic [LIT_W-1:0] unit_lit;
   logic             is_header;

   assign neg_lit   = '0 - cur_lit_reg;
   assign is_header = (bus.carb2sw == '0);

   // Slot 0 sits in the top bits; positions are kept, zeros never compacted.
   for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      assign lit[gi] = bus.carb2sw[CLA_W-1-gi*LIT_W -: LIT_W];
      assign sat[gi] = (lit[gi] != '0) && (lit[gi] == cur_lit_reg);
      assign red[gi] = (lit[gi] == neg_lit) ? '0 : lit[gi];
      assign nz[gi]  = (red[gi] != '0);
   end

   assign nz_cnt     = {1'b0, nz[0]} + {1'b0, nz[1]} + {1'b0, nz[2]};
   assign red_clause = {red[0], red[1], red[2]};
   // With exactly one survivor the OR of the slots is that literal.
   assign unit_lit   = red[0] | red[1] | red[2];

   always_comb begin
      clq_wr       = 1'b0;
      clq_data     = bus.carb2sw;
      ucq_in_wr    = 1'b0;
      conflict_set = 1'b0;
      ucq_out_pop  = 1'b0;
      active_next  = active_reg;
      cur_lit_next = cur_lit_reg;
      if (bus.carb2sw_valid) begin
         if (is_header) begin
            if (!ucq_out_empty) begin
               ucq_out_pop  = 1'b1;
               cur_lit_next = ucq_out_dout;
               active_next  = 1'b1;
            end else begin
               active_next  = 1'b0;
            end
         end else if (!active_reg) begin
            clq_wr = 1'b1;
         end else if (sat == 3'b000) begin
            if (nz_cnt == 2'd0) begin
               conflict_set = 1'b1;
            end else begin
               clq_wr    = 1'b1;
               clq_data  = red_clause;
               ucq_in_wr = (nz_cnt == 2'd1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_lit_reg  <= '0;
         active_reg   <= 1'b0;
         conflict_reg <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         cur_lit_reg  <= cur_lit_next;
         active_reg   <= active_next;
         if (conflict_set) conflict_reg <= 1'b1;
         if ((clq_wr && clq_full) || (ucq_in_wr && ucq_in_full)) overflow_reg <= 1'b1;
      end
   end

   assign bus.conflict = conflict_reg;
   assign bus.overflow = overflow_reg;

   sw_fifo #(.W(LIT_W), .DEPTH(DEPTH)) u_ucq_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.push),
      .wr_data (bus.uca2ucq),
      .rd_en   (ucq_out_pop),
      .dout    (ucq_out_dout),
      .empty   (ucq_out_empty),
      .full    (bus.UCQ_out_full)
   );

   sw_fifo #(.W(CLA_W), .DEPTH(DEPTH)) u_clq (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (clq_wr),
      .wr_data (clq_data),
      .rd_en   (bus.clq_pop),
      .dout    (bus.clq2sw),
      .empty   (bus.clq_empty),
      .full    (clq_full)
   );

   sw_fifo #(.W(LIT_W), .DEPTH(DEPTH)) u_ucq_in (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ucq_in_wr),
      .wr_data (unit_lit),
      .rd_en   (bus.ucarb2UCQ_in_pop),
      .dout    (bus.UCQ_in_dout),
      .empty   (bus.UCQ_in_empty),
      .full    (ucq_in_full)
   );
endmodule

// File: tb/tb_sw_engine_top.sv
// Scoreboard bench for sw_engine_top: expected CLQ / UCQ_in entries are queued
// as stimulus is driven and compared as the queues are drained.
module tb_sw_engine_top;
   localparam int LIT_W = 11;
   localparam int CLA_W = 33;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sw_engine_if #(.LIT_W(LIT_W), .CLA_W(CLA_W)) bus ();

   sw_engine_top #(.LIT_W(LIT_W), .CLA_W(CLA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [CLA_W-1:0] clq_exp [$];
   logic [LIT_W-1:0] ucq_exp [$];

   function automatic logic [LIT_W-1:0] L(input int v);
      return v[LIT_W-1:0];
   endfunction

   function automatic logic [CLA_W-1:0] mk(input int a, input int b, input int c);
      return {L(a), L(b), L(c)};
   endfunction

   // One clock of stimulus, starting and ending on a falling edge.
   task automatic cycle(input logic p, input int lit, input logic v,
                        input logic [CLA_W-1:0] c, input logic pu, input logic pc);
      bus.push             = p;
      bus.uca2ucq          = L(lit);
      bus.carb2sw_valid    = v;
      bus.carb2sw          = c;
      bus.ucarb2UCQ_in_pop = pu;
      bus.clq_pop          = pc;
      @(negedge clk);
      bus.push             = 1'b0;
      bus.uca2ucq          = '0;
      bus.carb2sw_valid    = 1'b0;
      bus.carb2sw          = '0;
      bus.ucarb2UCQ_in_pop = 1'b0;
      bus.clq_pop          = 1'b0;
   endtask

   task automatic push_lit(input int v);
      cycle(1'b1, v, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic header();
      cycle(1'b0, 0, 1'b1, '0, 1'b0, 1'b0);
   endtask

   task automatic clause(input logic [CLA_W-1:0] c);
      $display("[%0t] clause %h", $time, c);
      cycle(1'b0, 0, 1'b1, c, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clq_exp.delete();
      ucq_exp.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain_clq(input string nm);
      logic [CLA_W-1:0] exp;
      while (clq_exp.size() > 0) begin
         checks++;
         if (bus.clq_empty !== 1'b0) begin
            $display("FAIL %s clq_empty: got %b, required 0 (pending %h)", nm, bus.clq_empty, clq_exp[0]);
            errors++;
            clq_exp.delete();
         end else begin
            exp = clq_exp.pop_front();
            $display("[%0t] %s clq pop %h", $time, nm, bus.clq2sw);
            if (bus.clq2sw !== exp) begin
               $display("FAIL %s clq2sw: got %h, required %h", nm, bus.clq2sw, exp);
               errors++;
            end
            cycle(1'b0, 0, 1'b0, '0, 1'b0, 1'b1);
         end
      end
      checks++;
      if (bus.clq_empty !== 1'b1) begin
         $display("FAIL %s clq_drained: clq_empty got %b, required 1", nm, bus.clq_empty);
         errors++;
      end
   endtask

   task automatic drain_ucq(input string nm);
      logic [LIT_W-1:0] exp;
      while (ucq_exp.size() > 0) begin
         checks++;
         if (bus.UCQ_in_empty !== 1'b0) begin
            $display("FAIL %s UCQ_in_empty: got %b, required 0 (pending %h)", nm, bus.UCQ_in_empty, ucq_exp[0]);
            errors++;
            ucq_exp.delete();
         end else begin
            exp = ucq_exp.pop_front();
            $display("[%0t] %s UCQ_in pop %h", $time, nm, bus.UCQ_in_dout);
            if (bus.UCQ_in_dout !== exp) begin
               $display("FAIL %s UCQ_in_dout: got %h, required %h", nm, bus.UCQ_in_dout, exp);
               errors++;
            end
            cycle(1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
         end
      end
      checks++;
      if (bus.UCQ_in_empty !== 1'b1) begin
         $display("FAIL %s ucq_drained: UCQ_in_empty got %b, required 1", nm, bus.UCQ_in_empty);
         errors++;
      end
   endtask

   task automatic test_reset();
      push_lit(4);
      header();
      clause(mk(-4, 7, 0));
      clause(mk(-4, 0, 0));
      checks++;
      if (bus.conflict !== 1'b1) begin
         $display("FAIL reset_pre conflict: got %b, required 1", bus.conflict); errors++;
      end
      checks++;
      if (bus.clq_empty !== 1'b0) begin
         $display("FAIL reset_pre clq_empty: got %b, required 0", bus.clq_empty); errors++;
      end
      #2 rst_n = 1'b0;
      clq_exp.delete();
      ucq_exp.delete();
      #1;
      checks++;
      if ({bus.clq_empty, bus.UCQ_in_empty, bus.conflict, bus.overflow, bus.UCQ_out_full} !== 5'b11000) begin
         $display("FAIL reset flags: got %b, required 11000",
                  {bus.clq_empty, bus.UCQ_in_empty, bus.conflict, bus.overflow, bus.UCQ_out_full});
         errors++;
      end
      checks++;
      if (bus.clq2sw !== '0) begin
         $display("FAIL reset clq2sw: got %h, required 0", bus.clq2sw); errors++;
      end
      checks++;
      if (bus.UCQ_in_dout !== '0) begin
         $display("FAIL reset UCQ_in_dout: got %h, required 0", bus.UCQ_in_dout); errors++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Fresh state: no literal is active, so the clause passes unchanged.
      clq_exp.push_back(mk(-4, 7, 0));
      clause(mk(-4, 7, 0));
      checks++;
      if (bus.UCQ_in_empty !== 1'b1) begin
         $display("FAIL reset_post UCQ_in_empty: got %b, required 1", bus.UCQ_in_empty); errors++;
      end
      drain_clq("reset_post");
   endtask

   task automatic test_batch();
      do_reset();
      push_lit(-1);
      header();
      clq_exp.push_back(mk(0, 2, 7));
      clause(mk(1, 2, 7));
      clause(mk(2, -1, 5));
      clq_exp.push_back(mk(0, 3, 0));
      ucq_exp.push_back(L(3));
      clause(mk(0, 3, 1));
      clq_exp.push_back(mk(6, 3, 0));
      clause(mk(6, 3, 1));
      checks++;
      if (bus.conflict !== 1'b0) begin
         $display("FAIL batch conflict: got %b, required 0", bus.conflict); errors++;
      end
      drain_clq("batch");
      drain_ucq("batch");
   endtask

   task automatic test_no_header();
      do_reset();
      clq_exp.push_back(mk(1, 2, 7));
      clause(mk(1, 2, 7));
      checks++;
      if (bus.UCQ_in_empty !== 1'b1) begin
         $display("FAIL no_header UCQ_in_empty: got %b, required 1", bus.UCQ_in_empty); errors++;
      end
      push_lit(5);
      header();
      header();
      clq_exp.push_back(mk(-5, 1, 2));
      clause(mk(-5, 1, 2));
      drain_clq("no_header");
      drain_ucq("no_header");
   endtask

   task automatic test_back_to_back();
      do_reset();
      // Push and header on the same edge with UCQ_out empty: header sees empty.
      cycle(1'b1, 6, 1'b1, '0, 1'b0, 1'b0);
      clq_exp.push_back(mk(-6, 1, 2));
      clause(mk(-6, 1, 2));
      header();
      clq_exp.push_back(mk(0, 1, 2));
      clause(mk(-6, 1, 2));
      drain_clq("back_to_back");
      drain_ucq("back_to_back");
   endtask

   task automatic test_conflict();
      do_reset();
      push_lit(4);
      header();
      clause(mk(-4, 0, 0));
      checks++;
      if ({bus.conflict, bus.clq_empty, bus.UCQ_in_empty} !== 3'b111) begin
         $display("FAIL conflict flags: got %b, required 111",
                  {bus.conflict, bus.clq_empty, bus.UCQ_in_empty});
         errors++;
      end
      clq_exp.push_back(mk(5, 6, 0));
      clause(mk(5, 6, 0));
      checks++;
      if (bus.conflict !== 1'b1) begin
         $display("FAIL conflict sticky: got %b, required 1", bus.conflict); errors++;
      end
      drain_clq("conflict");
      drain_ucq("conflict");
   endtask

   task automatic test_overflow();
      do_reset();
      push_lit(9);
      header();
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (i < DEPTH) clq_exp.push_back(mk(1, 2, 3));
         clause(mk(1, 2, 3));
      end
      checks++;
      if (bus.overflow !== 1'b1) begin
         $display("FAIL overflow flag: got %b, required 1", bus.overflow); errors++;
      end
      checks++;
      if (bus.clq2sw !== mk(1, 2, 3)) begin
         $display("FAIL overflow head: got %h, required %h", bus.clq2sw, mk(1, 2, 3)); errors++;
      end
      drain_clq("overflow");
      checks++;
      if (bus.overflow !== 1'b1) begin
         $display("FAIL overflow sticky: got %b, required 1", bus.overflow); errors++;
      end
   endtask

   task automatic test_fifo_edges();
      do_reset();
      for (int i = 0; i < DEPTH; i++) push_lit(10 + i);
      checks++;
      if (bus.UCQ_out_full !== 1'b1) begin
         $display("FAIL ucq_out full: got %b, required 1", bus.UCQ_out_full); errors++;
      end
      push_lit(99);
      checks++;
      if (bus.overflow !== 1'b0) begin
         $display("FAIL ucq_out drop overflow: got %b, required 0", bus.overflow); errors++;
      end
      for (int i = 0; i < DEPTH; i++) header();
      checks++;
      if (bus.UCQ_out_full !== 1'b0) begin
         $display("FAIL ucq_out drained full: got %b, required 0", bus.UCQ_out_full); errors++;
      end
      clq_exp.push_back(mk(0, 5, 6));
      clause(mk(-17, 5, 6));
      // Ninth push must have been dropped, so this header finds UCQ_out empty.
      header();
      clq_exp.push_back(mk(-99, 5, 6));
      clause(mk(-99, 5, 6));
      drain_clq("ucq_out_edges");

      push_lit(4);
      header();
      clq_exp.push_back(mk(0, 7, 0));
      clause(mk(-4, 7, 0));
      checks++;
      if (bus.UCQ_in_dout !== L(7)) begin
         $display("FAIL ucq_in head: got %h, required %h", bus.UCQ_in_dout, L(7)); errors++;
      end
      clq_exp.push_back(mk(0, 0, 8));
      ucq_exp.push_back(L(8));
      cycle(1'b0, 0, 1'b1, mk(-4, 0, 8), 1'b1, 1'b0);
      drain_ucq("ucq_in_wr_pop");
      cycle(1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
      clq_exp.push_back(mk(0, 5, 0));
      ucq_exp.push_back(L(5));
      clause(mk(-4, 5, 0));
      drain_ucq("ucq_in_pop_empty");
      drain_clq("ucq_in_edges");
   endtask

   initial begin
      bus.push             = 1'b0;
      bus.uca2ucq          = '0;
      bus.carb2sw_valid    = 1'b0;
      bus.carb2sw          = '0;
      bus.ucarb2UCQ_in_pop = 1'b0;
      bus.clq_pop          = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_batch();
      test_no_header();
      test_back_to_back();
      test_conflict();
      test_overflow();
      test_fifo_edges();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
